// File: rtl/serial_limb_adder.sv
// serial_limb_adder: multi-cycle adder/subtractor. It processes LIMB bits per clock, least
// significant slice first, and passes the carry between slices through a register.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operation handshake (a, b, c_in, sub are sampled on accept)
//   a, b                WIDTH-bit operands
//   c_in                carry-in (add) / borrow-in (subtract)
//   sub                 0: a+b+c_in, 1: a-b-c_in
//   out_valid/out_ready result handshake
//   sum                 WIDTH-bit result, modulo 2^WIDTH
//   c_out               raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf                 two's-complement signed overflow
module serial_limb_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LIMB  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NLIMB = WIDTH / LIMB;
  localparam int unsigned CNTW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CNTW-1:0] LastCnt = CNTW'(NLIMB - 1);

  if (LIMB == 0 || LIMB > WIDTH || (WIDTH % LIMB) != 0) begin : g_param_check
    $fatal(1, "serial_limb_adder: WIDTH must be a non-zero multiple of LIMB");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
  logic              r_carry, w_carry_nxt;
  logic [WIDTH-1:0]  r_a, w_a_nxt;
  logic [WIDTH-1:0]  r_b, w_b_nxt;
  logic [WIDTH-1:0]  r_sum, w_sum_nxt;
  logic              r_c_out, w_c_out_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              r_out_valid;

  logic [LIMB-1:0]   w_a_sl;
  logic [LIMB-1:0]   w_b_sl;
  logic [LIMB:0]     w_res;

  assign in_ready  = (r_state == StIdle) && !rst;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;

  // Current slice of each operand; constant-offset mux keeps the select logic simple.
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int i = 0; i < int'(NLIMB); i++) begin
      if (r_cnt == CNTW'(i)) begin
        w_a_sl = r_a[i*LIMB +: LIMB];
        w_b_sl = r_b[i*LIMB +: LIMB];
      end
    end
    w_res = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{LIMB{1'b0}}, r_carry};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_carry_nxt = r_carry;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_sum_nxt   = r_sum;
    w_c_out_nxt = r_c_out;
    w_ovf_nxt   = r_ovf;
    unique case (r_state)
      StIdle: begin
        if (in_valid && in_ready) begin
          // Subtract as a + ~b + ~c_in, so the datapath is always an adder.
          w_a_nxt     = a;
          w_b_nxt     = sub ? ~b : b;
          w_carry_nxt = sub ? ~c_in : c_in;
          w_cnt_nxt   = '0;
          w_state_nxt = StBusy;
        end
      end
      StBusy: begin
        for (int i = 0; i < int'(NLIMB); i++) begin
          if (r_cnt == CNTW'(i)) w_sum_nxt[i*LIMB +: LIMB] = w_res[LIMB-1:0];
        end
        w_carry_nxt = w_res[LIMB];
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_cnt == LastCnt) begin
          // The top slice is current, so its MSBs are the operand and result sign bits.
          w_c_out_nxt = w_res[LIMB];
          w_ovf_nxt   = (w_a_sl[LIMB-1] == w_b_sl[LIMB-1]) && (w_res[LIMB-1] != w_a_sl[LIMB-1]);
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        if (out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_carry     <= w_carry_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_sum       <= w_sum_nxt;
      r_c_out     <= w_c_out_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= (w_state_nxt == StDone);
    end
  end

endmodule

// File: tb/tb_serial_limb_adder.sv
// Directed and streaming bench for serial_limb_adder. Three configurations (32/8, 32/32, 64/16)
// share one stimulus bus; 'sel' chooses which instance is driven and observed.
module tb_serial_limb_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, c_in, sub, out_ready;
  logic [63:0] op_a, op_b;
  int          sel;

  logic        iv0, iv1, iv2;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2, of0, of1, of2;
  logic [31:0] s0, s1;
  logic [63:0] s2;

  logic        m_in_ready, m_out_valid, m_c_out, m_ovf;
  logic [63:0] m_sum;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);

  serial_limb_adder #(.WIDTH(32), .LIMB(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(op_a[31:0]), .b(op_b[31:0]),
    .c_in(c_in), .sub(sub), .out_valid(ov0), .out_ready(out_ready), .sum(s0), .c_out(co0),
    .ovf(of0));

  serial_limb_adder #(.WIDTH(32), .LIMB(32)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(op_a[31:0]), .b(op_b[31:0]),
    .c_in(c_in), .sub(sub), .out_valid(ov1), .out_ready(out_ready), .sum(s1), .c_out(co1),
    .ovf(of1));

  serial_limb_adder #(.WIDTH(64), .LIMB(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(op_a), .b(op_b),
    .c_in(c_in), .sub(sub), .out_valid(ov2), .out_ready(out_ready), .sum(s2), .c_out(co2),
    .ovf(of2));

  always_comb begin
    m_in_ready  = ir0;
    m_out_valid = ov0;
    m_sum       = {32'b0, s0};
    m_c_out     = co0;
    m_ovf       = of0;
    if (sel == 1) begin
      m_in_ready = ir1; m_out_valid = ov1; m_sum = {32'b0, s1}; m_c_out = co1; m_ovf = of1;
    end else if (sel == 2) begin
      m_in_ready = ir2; m_out_valid = ov2; m_sum = s2; m_c_out = co2; m_ovf = of2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nlimb();
    return (sel == 1) ? 1 : 4;
  endfunction

  // Offer an operation and return the cycle index of its accept edge.
  task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic ic,
                       input logic is, input logic hold, output int acc);
    int n = 0;
    op_a = ia; op_b = ib; c_in = ic; sub = is; in_valid = 1'b1;
    while (!m_in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("accept_timeout", {63'b0, m_in_ready}, 64'd1);
    tick();
    acc = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_result(input int acc, output int lat);
    int n = 0;
    while (!m_out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("out_valid_seen", {63'b0, m_out_valid}, 64'd1);
    lat = cyc - acc;
  endtask

  task automatic check_res(input string tag, input logic [63:0] es, input logic ec,
                           input logic eo, input int lat);
    chk({tag, "_sum"}, m_sum, es);
    chk({tag, "_c_out"}, {63'b0, m_c_out}, {63'b0, ec});
    chk({tag, "_ovf"}, {63'b0, m_ovf}, {63'b0, eo});
    chk({tag, "_latency"}, 64'(lat), 64'(nlimb()));
  endtask

  // Consume the result and confirm the block is ready again the next cycle.
  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_after_hs"}, {63'b0, m_out_valid}, 64'd0);
    chk({tag, "_ready_after_hs"}, {63'b0, m_in_ready}, 64'd1);
  endtask

  // Reference: exact signed/unsigned arithmetic at the configured width.
  task automatic model(input logic [63:0] ma, input logic [63:0] mb, input logic mc,
                       input logic ms, input int w, output logic [63:0] s, output logic co,
                       output logic ov);
    logic [63:0]        mask;
    logic [64:0]        ua;
    logic [64:0]        ub;
    logic [64:0]        full;
    logic signed [66:0] sa;
    logic signed [66:0] sb;
    logic signed [66:0] res;
    logic signed [66:0] lim;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ua = {1'b0, ma & mask};
    ub = {1'b0, mb & mask};
    if (w == 64) begin
      sa = {{3{ma[63]}}, ma};
      sb = {{3{mb[63]}}, mb};
    end else begin
      sa = {{35{ma[31]}}, ma[31:0]};
      sb = {{35{mb[31]}}, mb[31:0]};
    end
    res = ms ? (sa - sb - 67'(mc)) : (sa + sb + 67'(mc));
    lim = 67'sd1 <<< (w - 1);
    ov  = (res >= lim) || (res < -lim);
    s   = res[63:0] & mask;
    if (ms) begin
      co = (ua >= ub + 65'(mc));
    end else begin
      full = ua + ub + 65'(mc);
      co = full[w];
    end
  endtask

  task automatic stream(input int cfg, input string tag);
    int          acc, prev, lat;
    logic [63:0] ra, rb, es;
    logic        rc, rs, ec, eo;
    sel = cfg;
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i == 3) rb = ra;
      if (cfg != 2) begin
        ra[63:32] = 32'b0;
        rb[63:32] = 32'b0;
      end
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rc, rs, (cfg == 2) ? 64 : 32, es, ec, eo);
      issue(ra, rb, rc, rs, 1'b1, acc);
      if (i > 0) chk({tag, "_period"}, 64'(acc - prev), 64'(nlimb() + 2));
      prev = acc;
      wait_result(acc, lat);
      check_res(tag, es, ec, eo, lat);
    end
    in_valid = 1'b0;
    tick();
    chk({tag, "_idle_after"}, {63'b0, m_in_ready}, 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int acc, lat;
    rst = 1'b1; in_valid = 1'b0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; sel = 0;

    // Reset state
    #2;
    chk("rst_out_valid", {63'b0, m_out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, m_in_ready}, 64'd0);
    chk("rst_sum", m_sum, 64'd0);
    chk("rst_c_out", {63'b0, m_c_out}, 64'd0);
    chk("rst_ovf", {63'b0, m_ovf}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {63'b0, m_in_ready}, 64'd1);

    // Basic add, carry ripple, signed overflow
    issue(64'd1, 64'd2, 1'b1, 1'b0, 1'b0, acc);
    wait_result(acc, lat);
    check_res("add_1_2_1", 64'd4, 1'b0, 1'b0, lat);
    handshake("add_1_2_1");

    issue(64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, acc);
    wait_result(acc, lat);
    check_res("ripple", 64'd0, 1'b1, 1'b0, lat);
    handshake("ripple");

    issue(64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, acc);
    wait_result(acc, lat);
    check_res("add_ovf", 64'h8000_0000, 1'b0, 1'b1, lat);
    handshake("add_ovf");

    // Subtract
    issue(64'd10, 64'd20, 1'b0, 1'b1, 1'b0, acc);
    wait_result(acc, lat);
    check_res("sub_10_20", 64'hFFFF_FFF6, 1'b0, 1'b0, lat);
    handshake("sub_10_20");

    issue(64'd25, 64'd10, 1'b1, 1'b1, 1'b0, acc);
    wait_result(acc, lat);
    check_res("sub_25_10_1", 64'd14, 1'b1, 1'b0, lat);
    handshake("sub_25_10_1");

    issue(64'h8000_0000, 64'd1, 1'b0, 1'b1, 1'b0, acc);
    wait_result(acc, lat);
    check_res("sub_ovf", 64'h7FFF_FFFF, 1'b1, 1'b1, lat);
    handshake("sub_ovf");

    // Backpressure: result held, stray in_valid ignored
    issue(64'd3, 64'd4, 1'b0, 1'b0, 1'b0, acc);
    wait_result(acc, lat);
    check_res("bp", 64'd7, 1'b0, 1'b0, lat);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        op_a = 64'd100; op_b = 64'd200; in_valid = 1'b1;
      end
      if (k == 2) in_valid = 1'b0;
      tick();
      chk("bp_hold_sum", m_sum, 64'd7);
      chk("bp_hold_c_out", {63'b0, m_c_out}, 64'd0);
      chk("bp_hold_ovf", {63'b0, m_ovf}, 64'd0);
      chk("bp_hold_in_ready", {63'b0, m_in_ready}, 64'd0);
      chk("bp_hold_out_valid", {63'b0, m_out_valid}, 64'd1);
    end
    handshake("bp");
    tick();
    chk("bp_no_queued_op", {63'b0, m_out_valid}, 64'd0);
    chk("bp_still_ready", {63'b0, m_in_ready}, 64'd1);

    // Asynchronous reset while busy (two limbs processed)
    issue(64'd9, 64'd9, 1'b0, 1'b0, 1'b0, acc);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {63'b0, m_out_valid}, 64'd0);
    chk("arst_sum", m_sum, 64'd0);
    chk("arst_in_ready", {63'b0, m_in_ready}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_rel_ready", {63'b0, m_in_ready}, 64'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("arst_no_result", {63'b0, m_out_valid}, 64'd0);
    end
    issue(64'd5, 64'd10, 1'b0, 1'b0, 1'b0, acc);
    wait_result(acc, lat);
    check_res("post_rst", 64'd15, 1'b0, 1'b0, lat);
    handshake("post_rst");

    // Back-to-back streaming against the reference model
    stream(0, "str_32_8");
    stream(1, "str_32_32");
    stream(2, "str_64_16");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
